// File: rtl/bsg_cordic_hyp_pkg.sv
// Shared definitions for the hyperbolic CORDIC pipeline.
//
// Contents:
//   hyp_mode_e      per-transaction operating mode (rotation / vectoring)
//   num_stages()    stage count N for a given iteration range
//   stage_shift()   shift index i executed by pipeline stage k (0-based);
//                   i = 4 and i = 13 appear twice
//   atanh_q62()     atanh(2^-i), i = 1..31, at 62 fraction bits
//   atanh_fx()      the same angle right-aligned to frac bits, round-to-nearest
//   kinv_fx()       1/K_h for the stage list, rounded to frac bits
//   kh_fx()         K_h for the stage list, rounded to frac bits
//   zmax_fx()       rotation convergence limit ZMAX = 1.1182 at frac bits
//
// All functions are constant functions evaluated at elaboration time.
package bsg_cordic_hyp_pkg;

  typedef enum logic {
    e_hyp_rotate = 1'b0,
    e_hyp_vector = 1'b1
  } hyp_mode_e;

  localparam int atanh_frac_c = 62;
  localparam int max_shift_c  = 31;

  function automatic int num_stages(input int iter);
    return iter + ((iter >= 4) ? 1 : 0) + ((iter >= 13) ? 1 : 0);
  endfunction

  // Stage list 1,2,3,4,4,5,..,13,13,14,..: closed form of the repeat pattern.
  function automatic int stage_shift(input int k);
    if (k < 4)       return k + 1;
    else if (k < 14) return k;
    else             return k - 1;
  endfunction

  // atanh(t) = t + t^3/3 + t^5/5 + ... with t = 2^-i. Every power of t is an
  // exact power of two, so each term is one integer divide. Summed with ten
  // guard bits (Q72) and rounded to Q62.
  function automatic logic [63:0] atanh_q62(input int i);
    logic [79:0] acc;
    logic [79:0] term;
    int          e;
    acc = '0;
    for (int k = 0; k < 40; k++) begin
      e = 72 - i * (2 * k + 1);
      if (e >= 0) begin
        term = (80'd1 << e) / 80'(2 * k + 1);
        acc  = acc + term;
      end
    end
    return 64'((acc + (80'd1 << 9)) >> 10);
  endfunction

  function automatic logic [63:0] atanh_fx(input int i, input int frac);
    logic [63:0] t;
    t = atanh_q62(i);
    return (t + (64'd1 << (atanh_frac_c - 1 - frac))) >> (atanh_frac_c - frac);
  endfunction

  // K_h^2 = prod (1 - 2^-2i) over the stage list, in Q62.
  function automatic logic [63:0] kh_sq_q62(input int iter);
    logic [63:0] p;
    int          n;
    p = 64'd1 << atanh_frac_c;
    n = num_stages(iter);
    for (int k = 0; k < n; k++) begin
      p = p - (p >> (2 * stage_shift(k)));
    end
    return p;
  endfunction

  function automatic logic [63:0] isqrt128(input logic [127:0] a);
    logic [63:0] root;
    logic [63:0] cand;
    root = '0;
    for (int b = 63; b >= 0; b--) begin
      cand = root | (64'd1 << b);
      if (({64'd0, cand} * {64'd0, cand}) <= a) root = cand;
    end
    return root;
  endfunction

  // K_h in Q62 is sqrt(K_h^2 in Q124).
  function automatic logic [63:0] kh_q62(input int iter);
    return isqrt128({64'd0, kh_sq_q62(iter)} << atanh_frac_c);
  endfunction

  function automatic logic [63:0] kh_fx(input int iter, input int frac);
    logic [63:0] s;
    s = kh_q62(iter);
    return (s + (64'd1 << (atanh_frac_c - 1 - frac))) >> (atanh_frac_c - frac);
  endfunction

  function automatic logic [63:0] kinv_fx(input int iter, input int frac);
    logic [127:0] root;
    logic [127:0] num;
    root = {64'd0, kh_q62(iter)};
    num  = (128'd1 << (frac + atanh_frac_c)) + (root >> 1);
    return 64'(num / root);
  endfunction

  function automatic logic [63:0] zmax_fx(input int frac);
    return ((64'd11182 << frac) + 64'd5000) / 64'd10000;
  endfunction

endpackage

// File: rtl/bsg_cordic_hyperbolic_pipe_if.sv
// Handshake and data bundle of the hyperbolic CORDIC pipeline.
//
// Input side : v_i, ready_o, mode_i, x_i, y_i, z_i, tag_i
// Output side: v_o, ready_i, mode_o, x_o, y_o, z_o, tag_o, err_o
//
// modport slave  - the pipeline itself
// modport master - the environment that feeds and drains it
interface bsg_cordic_hyperbolic_pipe_if #(
  parameter int width_p     = 32,
  parameter int tag_width_p = 8
) ();
  import bsg_cordic_hyp_pkg::*;

  logic                      v_i;
  logic                      ready_o;
  hyp_mode_e                 mode_i;
  logic signed [width_p-1:0] x_i;
  logic signed [width_p-1:0] y_i;
  logic signed [width_p-1:0] z_i;
  logic [tag_width_p-1:0]    tag_i;

  logic                      v_o;
  logic                      ready_i;
  hyp_mode_e                 mode_o;
  logic signed [width_p-1:0] x_o;
  logic signed [width_p-1:0] y_o;
  logic signed [width_p-1:0] z_o;
  logic [tag_width_p-1:0]    tag_o;
  logic                      err_o;

  modport slave (
    input  v_i, mode_i, x_i, y_i, z_i, tag_i, ready_i,
    output ready_o, v_o, mode_o, x_o, y_o, z_o, tag_o, err_o
  );

  modport master (
    output v_i, mode_i, x_i, y_i, z_i, tag_i, ready_i,
    input  ready_o, v_o, mode_o, x_o, y_o, z_o, tag_o, err_o
  );

endinterface

// File: rtl/bsg_cordic_hyp_stage.sv
// One combinational hyperbolic CORDIC micro-rotation.
//
//   x' = x + d*(y >>> shift_p)
//   y' = y + d*(x >>> shift_p)
//   z' = z - d*angle_p          (angle_p = atanh(2^-shift_p) at frac bits)
//
// Rotation drives z toward 0 (d = +1 when z >= 0); vectoring drives y toward
// 0 (d = +1 when y < 0). All sums wrap at width_p.
//
// Ports: mode_i, x_i, y_i, z_i in; x_o, y_o, z_o out.
module bsg_cordic_hyp_stage
  import bsg_cordic_hyp_pkg::*;
#(
  parameter int                 width_p = 32,
  parameter int                 shift_p = 1,
  parameter logic [width_p-1:0] angle_p = '0
) (
  input  hyp_mode_e                 mode_i,
  input  logic signed [width_p-1:0] x_i,
  input  logic signed [width_p-1:0] y_i,
  input  logic signed [width_p-1:0] z_i,
  output logic signed [width_p-1:0] x_o,
  output logic signed [width_p-1:0] y_o,
  output logic signed [width_p-1:0] z_o
);

  localparam logic signed [width_p-1:0] angle_lp = angle_p;

  logic signed [width_p-1:0] x_sh;
  logic signed [width_p-1:0] y_sh;
  logic                      d_pos;

  assign x_sh  = x_i >>> shift_p;
  assign y_sh  = y_i >>> shift_p;

  // Sign bits decide direction: z >= 0 in rotation, y < 0 in vectoring.
  assign d_pos = (mode_i == e_hyp_rotate) ? ~z_i[width_p-1] : y_i[width_p-1];

  assign x_o   = d_pos ? (x_i + y_sh) : (x_i - y_sh);
  assign y_o   = d_pos ? (y_i + x_sh) : (y_i - x_sh);
  assign z_o   = d_pos ? (z_i - angle_lp) : (z_i + angle_lp);

endmodule

// File: rtl/bsg_cordic_hyperbolic_pipe.sv
// Fully pipelined hyperbolic CORDIC with per-transaction mode select.
//
// Rotation : x_o = cosh(z_i), y_o = sinh(z_i), z_o ~ 0
// Vectoring: x_o = K_h*sqrt(x_i^2 - y_i^2), y_o ~ 0, z_o = z_i + atanh(y_i/x_i)
//
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   io         bsg_cordic_hyperbolic_pipe_if.slave (valid/ready in and out,
//              operands, mode, tag, err)
//
// Pipeline: one input register followed by one register per stage, N+1 deep.
// Every register shares one enable; a stalled output (v_o & ~ready_i) freezes
// the whole pipe, bubbles included, and drops ready_o.
module bsg_cordic_hyperbolic_pipe
  import bsg_cordic_hyp_pkg::*;
#(
  parameter int width_p     = 32,
  parameter int frac_p      = 28,
  parameter int iter_p      = 16,
  parameter int tag_width_p = 8
) (
  input logic                        clk_i,
  input logic                        reset_n_i,
  bsg_cordic_hyperbolic_pipe_if.slave io
);

  localparam int stages_lp = num_stages(iter_p);

  localparam logic signed [width_p-1:0] kinv_lp = width_p'(kinv_fx(iter_p, frac_p));
  localparam logic signed [width_p-1:0] zmax_lp = width_p'(zmax_fx(frac_p));
  localparam logic signed [width_p-1:0] zmin_lp = -zmax_lp;
  localparam logic signed [width_p-1:0] zero_lp = '0;

  // Index 0 is the input register; index s holds the result of stage s.
  logic                      v_r    [0:stages_lp];
  hyp_mode_e                 mode_r [0:stages_lp];
  logic                      err_r  [0:stages_lp];
  logic [tag_width_p-1:0]    tag_r  [0:stages_lp];
  logic signed [width_p-1:0] x_r    [0:stages_lp];
  logic signed [width_p-1:0] y_r    [0:stages_lp];
  logic signed [width_p-1:0] z_r    [0:stages_lp];

  logic signed [width_p-1:0] x_n    [1:stages_lp];
  logic signed [width_p-1:0] y_n    [1:stages_lp];
  logic signed [width_p-1:0] z_n    [1:stages_lp];

  logic                      stall;
  logic                      en;

  // ready_o depends only on the output slot and ready_i, never on v_i.
  assign stall      = v_r[stages_lp] & ~io.ready_i;
  assign en         = ~stall;
  assign io.ready_o = en;

  // Input-stage operand selection and convergence-domain check.
  logic signed [width_p-1:0] x_in;
  logic signed [width_p-1:0] y_in;
  logic                      err_in;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value unassigned and no latch forms.
    x_in   = io.x_i;
    y_in   = io.y_i;
    err_in = 1'b0;
    if (io.mode_i == e_hyp_rotate) begin
      x_in   = kinv_lp;
      y_in   = zero_lp;
      err_in = (io.z_i > zmax_lp) || (io.z_i < zmin_lp);
    end else begin
      // x <= 0 is tested first, so -x_i below cannot overflow on a live case.
      err_in = (io.x_i <= zero_lp) || (io.y_i >= io.x_i) || (io.y_i <= -io.x_i);
    end
  end

  for (genvar s = 1; s <= stages_lp; s++) begin : g_stage
    bsg_cordic_hyp_stage #(
      .width_p (width_p),
      .shift_p (stage_shift(s - 1)),
      .angle_p (width_p'(atanh_fx(stage_shift(s - 1), frac_p)))
    ) stage (
      .mode_i (mode_r[s-1]),
      .x_i    (x_r[s-1]),
      .y_i    (y_r[s-1]),
      .z_i    (z_r[s-1]),
      .x_o    (x_n[s]),
      .y_o    (y_n[s]),
      .z_o    (z_n[s])
    );
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: the datapath registers are reset as well as the valid bits, so
      // every output reads 0 while reset is held, not just v_o.
      for (int s = 0; s <= stages_lp; s++) begin
        v_r[s]    <= 1'b0;
        mode_r[s] <= e_hyp_rotate;
        err_r[s]  <= 1'b0;
        tag_r[s]  <= '0;
        x_r[s]    <= '0;
        y_r[s]    <= '0;
        z_r[s]    <= '0;
      end
    end else if (en) begin
      // NOTE: sequential state uses non-blocking '<=' so every stage reads its
      // neighbour's pre-edge value regardless of statement order.
      v_r[0]    <= io.v_i;
      mode_r[0] <= io.mode_i;
      err_r[0]  <= err_in;
      tag_r[0]  <= io.tag_i;
      x_r[0]    <= x_in;
      y_r[0]    <= y_in;
      z_r[0]    <= io.z_i;
      for (int s = 1; s <= stages_lp; s++) begin
        v_r[s]    <= v_r[s-1];
        mode_r[s] <= mode_r[s-1];
        err_r[s]  <= err_r[s-1];
        tag_r[s]  <= tag_r[s-1];
        x_r[s]    <= x_n[s];
        y_r[s]    <= y_n[s];
        z_r[s]    <= z_n[s];
      end
    end
  end

  assign io.v_o    = v_r[stages_lp];
  assign io.mode_o = mode_r[stages_lp];
  assign io.err_o  = err_r[stages_lp];
  assign io.tag_o  = tag_r[stages_lp];
  assign io.x_o    = x_r[stages_lp];
  assign io.y_o    = y_r[stages_lp];
  assign io.z_o    = z_r[stages_lp];

endmodule

// File: tb/tb_bsg_cordic_hyperbolic_pipe.sv
// Directed bench for bsg_cordic_hyperbolic_pipe: default build (N = 18) and
// an iter_p = 8 build (N = 9). Expected values are hand-computed constants in
// Q4.28.
module tb_bsg_cordic_hyperbolic_pipe;
  import bsg_cordic_hyp_pkg::*;

  localparam longint tol14_c = 64'sd1 << 14;  // 2^-14 in Q28
  localparam longint tol8_c  = 64'sd1 << 20;  // 2^-8  in Q28

  localparam real cosh_05_c  = 1.1276259652;
  localparam real sinh_05_c  = 0.5210953055;
  localparam real atanh_06_c = 0.6931471806;
  localparam real kh_18_c    = 0.82816;
  localparam real cosh_025_c = 1.0314130645;
  localparam real sinh_025_c = 0.2526123168;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bsg_cordic_hyperbolic_pipe_if #(.width_p(32), .tag_width_p(8)) io  ();
  bsg_cordic_hyperbolic_pipe_if #(.width_p(32), .tag_width_p(8)) io8 ();

  bsg_cordic_hyperbolic_pipe #(
    .width_p(32), .frac_p(28), .iter_p(16), .tag_width_p(8)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .io        (io)
  );

  bsg_cordic_hyperbolic_pipe #(
    .width_p(32), .frac_p(28), .iter_p(8), .tag_width_p(8)
  ) dut8 (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .io        (io8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp, input longint tol = 0);
    logic signed [63:0] diff;
    checks++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if ($isunknown(obs) || diff > tol) begin
      errors++;
      $display("FAIL %s: observed %0d, expected %0d (tolerance %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic logic signed [31:0] to_fx(input real r);
    return $rtoi(r * 268435456.0);
  endfunction

  task automatic drive(input hyp_mode_e m, input real x, input real y,
                       input real z, input logic [7:0] tag);
    io.v_i    = 1'b1;
    io.mode_i = m;
    io.x_i    = to_fx(x);
    io.y_i    = to_fx(y);
    io.z_i    = to_fx(z);
    io.tag_i  = tag;
  endtask

  // Caller has driven io at a negedge with an empty pipe and ready_i = 1.
  // Returns the number of rising edges from accept (counted as 1) to v_o.
  task automatic run_one(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      io.v_i = 1'b0;
      lat++;
    end while (!io.v_o && lat < 60);
  endtask

  task automatic err_case(input string tag, input hyp_mode_e m, input real x,
                          input real y, input real z, input logic exp_err);
    int lat;
    @(negedge clk);
    drive(m, x, y, z, 8'h11);
    run_one(lat);
    check(tag, io.err_o, exp_err);
  endtask

  // Stream transaction k: even k rotation, odd k vectoring; sign flips every 2.
  task automatic stream_drive(input int k);
    if (k % 2 == 0) drive(e_hyp_rotate, 0.0, 0.0, ((k / 2) % 2 == 1) ? -0.5 : 0.5, 8'(k));
    else            drive(e_hyp_vector, 1.25, ((k / 2) % 2 == 1) ? -0.75 : 0.75, 0.0, 8'(k));
  endtask

  task automatic stream_check(input int k);
    real sgn;
    sgn = ((k / 2) % 2 == 1) ? -1.0 : 1.0;
    check($sformatf("s%0d_tag", k), io.tag_o, k);
    check($sformatf("s%0d_err", k), io.err_o, 0);
    if (k % 2 == 0) begin
      check($sformatf("s%0d_mode", k), io.mode_o, e_hyp_rotate);
      check($sformatf("s%0d_x", k), io.x_o, to_fx(cosh_05_c), tol14_c);
      check($sformatf("s%0d_y", k), io.y_o, to_fx(sgn * sinh_05_c), tol14_c);
    end else begin
      check($sformatf("s%0d_mode", k), io.mode_o, e_hyp_vector);
      check($sformatf("s%0d_x", k), io.x_o, to_fx(kh_18_c), tol14_c);
      check($sformatf("s%0d_z", k), io.z_o, to_fx(sgn * atanh_06_c), tol14_c);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int                 lat;
    int                 sent;
    int                 recv;
    bit                 prev_stall;
    logic signed [31:0] held_x;
    logic [7:0]         held_tag;

    rst_n      = 1'b0;
    io.v_i     = 1'b0;  io.mode_i  = e_hyp_rotate; io.ready_i  = 1'b1;
    io.x_i     = '0;    io.y_i     = '0; io.z_i     = '0; io.tag_i  = '0;
    io8.v_i    = 1'b0;  io8.mode_i = e_hyp_rotate; io8.ready_i = 1'b1;
    io8.x_i    = '0;    io8.y_i    = '0; io8.z_i    = '0; io8.tag_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_v_o", io.v_o, 0);
    check("rst_ready_o", io.ready_o, 1);
    check("rst_x_o", io.x_o, 0);
    check("rst_y_o", io.y_o, 0);
    check("rst_z_o", io.z_o, 0);
    check("rst_tag_o", io.tag_o, 0);
    check("rst_mode_o", io.mode_o, 0);
    check("rst_err_o", io.err_o, 0);
    check("rst8_v_o", io8.v_o, 0);
    check("rst8_ready_o", io8.ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Rotation z = 0.5
    @(negedge clk);
    drive(e_hyp_rotate, 0.0, 0.0, 0.5, 8'hA5);
    run_one(lat);
    check("rot_latency", lat, 19);
    check("rot_x_cosh", io.x_o, to_fx(cosh_05_c), tol14_c);
    check("rot_y_sinh", io.y_o, to_fx(sinh_05_c), tol14_c);
    check("rot_z_zero", io.z_o, 0, tol14_c);
    check("rot_err", io.err_o, 0);
    check("rot_tag", io.tag_o, 8'hA5);
    check("rot_mode", io.mode_o, e_hyp_rotate);

    // Vectoring x = 1.25, y = 0.75
    @(negedge clk);
    drive(e_hyp_vector, 1.25, 0.75, 0.0, 8'h5A);
    run_one(lat);
    check("vec_latency", lat, 19);
    check("vec_z_atanh", io.z_o, to_fx(atanh_06_c), tol14_c);
    check("vec_x_gain", io.x_o, to_fx(kh_18_c), tol14_c);
    check("vec_y_zero", io.y_o, 0, tol14_c);
    check("vec_err", io.err_o, 0);
    check("vec_tag", io.tag_o, 8'h5A);
    check("vec_mode", io.mode_o, e_hyp_vector);

    // Convergence-domain flag
    err_case("err_rot_pos", e_hyp_rotate, 0.0, 0.0, 1.5, 1'b1);
    err_case("err_rot_neg", e_hyp_rotate, 0.0, 0.0, -1.5, 1'b1);
    err_case("ok_rot_1p0", e_hyp_rotate, 0.0, 0.0, 1.0, 1'b0);
    err_case("err_vec_eq", e_hyp_vector, 0.5, 0.5, 0.0, 1'b1);
    err_case("err_vec_negeq", e_hyp_vector, 0.5, -0.5, 0.0, 1'b1);
    err_case("err_vec_xneg", e_hyp_vector, -1.0, 0.0, 0.0, 1'b1);
    err_case("ok_vec", e_hyp_vector, 1.0, -0.5, 0.0, 1'b0);

    // 40 back-to-back mixed-mode transactions with random backpressure
    sent       = 0;
    recv       = 0;
    prev_stall = 1'b0;
    held_x     = '0;
    held_tag   = '0;
    for (int cyc = 0; cyc < 3000 && recv < 40; cyc++) begin
      @(negedge clk);
      io.ready_i = ($urandom_range(0, 9) >= 3);
      if (sent < 40) stream_drive(sent);
      else           io.v_i = 1'b0;
      #1;
      check("ready_o_rule", io.ready_o, !(io.v_o && !io.ready_i));
      if (prev_stall) begin
        check("stall_hold_x", io.x_o, held_x);
        check("stall_hold_tag", io.tag_o, held_tag);
      end
      prev_stall = io.v_o && !io.ready_i;
      held_x     = io.x_o;
      held_tag   = io.tag_o;
      if (io.v_o && io.ready_i) begin
        stream_check(recv);
        recv++;
      end
      if (io.v_i && io.ready_o) sent++;
    end
    check("stream_sent", sent, 40);
    check("stream_recv", recv, 40);
    @(negedge clk);
    io.v_i     = 1'b0;
    io.ready_i = 1'b1;
    repeat (25) @(negedge clk);
    check("stream_drained", io.v_o, 0);

    // Asynchronous reset with the pipe full and producing
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      drive(e_hyp_rotate, 0.0, 0.0, 0.5, 8'(k));
    end
    @(negedge clk);
    io.v_i = 1'b0;
    check("pre_rst_v_o", io.v_o, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_v_o", io.v_o, 0);
    check("midrst_x_o", io.x_o, 0);
    check("midrst_tag_o", io.tag_o, 0);
    check("midrst_ready_o", io.ready_o, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(e_hyp_rotate, 0.0, 0.0, 0.5, 8'h77);
    run_one(lat);
    check("postrst_latency", lat, 19);
    check("postrst_tag", io.tag_o, 8'h77);
    check("postrst_x", io.x_o, to_fx(cosh_05_c), tol14_c);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("postrst_no_stale", io.v_o, 0);
    end

    // iter_p = 8 build, rotation z = -0.25
    @(negedge clk);
    io8.v_i    = 1'b1;
    io8.mode_i = e_hyp_rotate;
    io8.z_i    = to_fx(-0.25);
    io8.tag_i  = 8'h3C;
    lat = 0;
    do begin
      @(negedge clk);
      io8.v_i = 1'b0;
      lat++;
    end while (!io8.v_o && lat < 60);
    check("n9_latency", lat, 10);
    check("n9_y_sinh", io8.y_o, to_fx(-sinh_025_c), tol8_c);
    check("n9_x_cosh", io8.x_o, to_fx(cosh_025_c), tol8_c);
    check("n9_z_zero", io8.z_o, 0, tol8_c);
    check("n9_err", io8.err_o, 0);
    check("n9_mode", io8.mode_o, e_hyp_rotate);
    check("n9_tag", io8.tag_o, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
